// File: rtl/alarm_s00_axi_core.sv
// alarm_s00_axi_core
// AXI4-Lite slave register file plus alarm engine.
// A prescaler divides the clock into ticks. Each tick advances TIME, which
// wraps at WRAP_VAL. When the new TIME equals ALARM, a sticky FIRED flag is
// set and a one-cycle alarm pulse is emitted.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w* / s00_axi_b* : AXI4-Lite write channels
//   s00_axi_ar* / s00_axi_r*              : AXI4-Lite read channels
//   irq         : level interrupt, STATUS.FIRED & CTRL.IRQ_EN (registered)
//   alarm_pulse : one-cycle pulse for each alarm match (registered)
//
// Register map (address bits [3:2]):
//   0x0 CTRL   : bit0 EN, bit1 IRQ_EN, bits[31:2] plain storage
//   0x4 TIME   : live counter, writable
//   0x8 ALARM  : compare value
//   0xC STATUS : bit0 FIRED (write 1 to clear), bit1 mirrors CTRL.EN
module alarm_s00_axi_core #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned CLK_PER_TICK       = 100000000,
  parameter int unsigned WRAP_VAL           = 86400
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]                    s00_axi_awprot,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
  input  logic [3:0]                    s00_axi_wstrb,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]                    s00_axi_arprot,
  input  logic                          s00_axi_arvalid,
  output logic                          s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0]                    s00_axi_rresp,
  output logic                          s00_axi_rvalid,
  input  logic                          s00_axi_rready,
  output logic                          irq,
  output logic                          alarm_pulse
);

  localparam logic [31:0] PRESC_TC  = 32'(CLK_PER_TICK - 1);
  localparam logic [31:0] WRAP_LAST = 32'(WRAP_VAL - 1);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_TIME   = 2'd1;
  localparam logic [1:0] A_ALARM  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] time_q, time_d;
  logic [31:0] alarm_q, alarm_d;
  logic [31:0] presc_q, presc_d;
  logic        fired_q, fired_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        pulse_q, pulse_d;

  logic        wr_hs_s, rd_hs_s, tick_s, match_s;
  logic        wr_ctrl_s, wr_time_s, wr_alarm_s, wr_status_s;
  logic [31:0] time_inc_s, rd_mux_s;
  logic [1:0]  wsel_s;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_s;
  assign unused_s = ^{s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Handshake decode, tick/match detection and next-state computation.
  always_comb begin
    wsel_s      = s00_axi_awaddr[3:2];
    wr_hs_s     = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    rd_hs_s     = arready_q & s00_axi_arvalid;
    wr_ctrl_s   = wr_hs_s && (wsel_s == A_CTRL);
    wr_time_s   = wr_hs_s && (wsel_s == A_TIME);
    wr_alarm_s  = wr_hs_s && (wsel_s == A_ALARM);
    wr_status_s = wr_hs_s && (wsel_s == A_STATUS);

    // Tick uses the pre-edge EN, so a CTRL write clearing EN cannot cancel it.
    tick_s     = ctrl_q[0] && (presc_q == PRESC_TC);
    time_inc_s = (time_q >= WRAP_LAST) ? 32'd0 : (time_q + 32'd1);
    // A TIME write on the tick edge overrides the tick, so no compare then.
    match_s    = tick_s && !wr_time_s && (time_inc_s == alarm_q);

    ctrl_d  = wr_ctrl_s  ? apply_strb(ctrl_q,  s00_axi_wdata, s00_axi_wstrb) : ctrl_q;
    alarm_d = wr_alarm_s ? apply_strb(alarm_q, s00_axi_wdata, s00_axi_wstrb) : alarm_q;

    if (wr_time_s) begin
      time_d = apply_strb(time_q, s00_axi_wdata, s00_axi_wstrb);
    end else if (tick_s) begin
      time_d = time_inc_s;
    end else begin
      time_d = time_q;
    end

    if (wr_time_s) begin
      presc_d = 32'd0;
    end else if (ctrl_q[0]) begin
      presc_d = tick_s ? 32'd0 : (presc_q + 32'd1);
    end else begin
      presc_d = presc_q;
    end

    // Set has priority over the write-1-to-clear.
    if (match_s) begin
      fired_d = 1'b1;
    end else if (wr_status_s && s00_axi_wstrb[0] && s00_axi_wdata[0]) begin
      fired_d = 1'b0;
    end else begin
      fired_d = fired_q;
    end

    pulse_d = match_s;
    irq_d   = fired_q & ctrl_q[1];

    awready_d = ~awready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end else if (wr_hs_s) begin
      bvalid_d = 1'b1;
    end else begin
      bvalid_d = bvalid_q;
    end

    case (s00_axi_araddr[3:2])
      A_CTRL:   rd_mux_s = ctrl_q;
      A_TIME:   rd_mux_s = time_q;
      A_ALARM:  rd_mux_s = alarm_q;
      A_STATUS: rd_mux_s = {30'd0, ctrl_q[0], fired_q};
      default:  rd_mux_s = 32'd0;
    endcase

    arready_d = ~arready_q & s00_axi_arvalid & ~rvalid_q;
    rdata_d   = rd_hs_s ? rd_mux_s : rdata_q;
    if (rd_hs_s) begin
      rvalid_d = 1'b1;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_q    <= 32'd0;
      time_q    <= 32'd0;
      alarm_q   <= 32'd0;
      presc_q   <= 32'd0;
      fired_q   <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      irq_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      time_q    <= time_d;
      alarm_q   <= alarm_d;
      presc_q   <= presc_d;
      fired_q   <= fired_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      pulse_q   <= pulse_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rvalid  = rvalid_q;
  assign irq             = irq_q;
  assign alarm_pulse     = pulse_q;

endmodule

// File: tb/tb_alarm_s00_axi_core.sv
module tb_alarm_s00_axi_core;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        irq;
  logic        alarm_pulse;

  int pass_cnt = 0;
  int total_cnt = 0;

  alarm_s00_axi_core #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .CLK_PER_TICK(4),
    .WRAP_VAL(10)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr),
    .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),
    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .irq(irq),
    .alarm_pulse(alarm_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic aw_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) break;
    end
    chk("awready_seen", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic b_wait();
    bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) break;
      @(posedge clk); #1;
    end
    chk("bvalid_seen", {30'd0, bresp, bvalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_issue(a, d, s);
    b_wait();
  endtask

  task automatic ar_issue(input logic [3:0] a);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) break;
    end
    chk("arready_seen", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic r_wait(output logic [31:0] d);
    rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) break;
      @(posedge clk); #1;
    end
    chk("rvalid_seen", {30'd0, rresp, rvalid}, 32'd1);
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ar_issue(a);
    r_wait(d);
    chk(tag, d, exp);
  endtask

  initial begin
    int pulse_cnt;
    int pulse_at;

    awaddr = 4'd0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0;
    wvalid = 1'b0; bready = 1'b1; araddr = 4'd0; arprot = 3'd0; arvalid = 1'b0;
    rready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and plain readback
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pulse", {31'd0, alarm_pulse}, 32'd0);
    read_chk("rst_ctrl", 4'h0, 32'h0000_0000);
    read_chk("rst_time", 4'h4, 32'h0000_0000);
    read_chk("rst_alarm", 4'h8, 32'h0000_0000);
    read_chk("rst_status", 4'hC, 32'h0000_0000);
    axi_write(4'h0, 32'hFFFF_FFFC, 4'hF);
    read_chk("ctrl_rb", 4'h0, 32'hFFFF_FFFC);
    chk("ctrl_irq", {31'd0, irq}, 32'd0);

    // Counting and wrap; CTRL write lands on edge W, task returns at W+1
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    repeat (2) @(posedge clk); #1;            // W+3
    read_chk("time_9", 4'h4, 32'd9);          // sampled after W+4 tick
    @(posedge clk); #1;                       // W+7
    read_chk("time_wrap0", 4'h4, 32'd0);      // sampled after W+8 tick
    axi_write(4'h0, 32'd0, 4'hF);             // EN cleared on W+12 tick edge
    repeat (40) @(posedge clk); #1;
    read_chk("time_frozen", 4'h4, 32'd1);

    // Alarm fire
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd5, 4'hF);
    axi_write(4'h0, 32'd3, 4'hF);             // W, returns at W+1
    pulse_cnt = 0;
    pulse_at = 0;
    for (int i = 2; i <= 16; i++) begin
      @(posedge clk); #1;
      if (alarm_pulse) begin
        pulse_cnt++;
        pulse_at = i;
      end
    end
    chk("pulse_count", pulse_cnt, 32'd1);
    chk("pulse_edge", pulse_at, 32'd12);
    read_chk("status_fired", 4'hC, 32'h3);
    chk("irq_set", {31'd0, irq}, 32'd1);
    axi_write(4'hC, 32'd1, 4'hF);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    read_chk("status_w1c", 4'hC, 32'h2);
    axi_write(4'h0, 32'd0, 4'hF);

    // Byte strobes
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h8, 32'hAABB_CCDD, 4'b0011);
    read_chk("strb_low", 4'h8, 32'h0000_CCDD);
    axi_write(4'h8, 32'h1122_3344, 4'b1000);
    read_chk("strb_top", 4'h8, 32'h1100_CCDD);

    // Write backpressure
    bready = 1'b0;
    aw_issue(4'h8, 32'h1234_5678, 4'hF);
    awaddr = 4'h8; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
      chk("bp_awready_low", {31'd0, awready}, 32'd0);
    end
    b_wait();
    chk("bp_bvalid_clr", {31'd0, bvalid}, 32'd0);
    aw_issue(4'h8, 32'h0BAD_F00D, 4'hF);
    chk("bp_bvalid_2nd", {31'd0, bvalid}, 32'd1);
    b_wait();
    read_chk("bp_alarm", 4'h8, 32'h0BAD_F00D);

    // Read backpressure
    rready = 1'b0;
    ar_issue(4'h8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rbp_rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rbp_rdata_hold", rdata, 32'h0BAD_F00D);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rbp_rvalid_clr", {31'd0, rvalid}, 32'd0);

    // Collisions
    axi_write(4'hC, 32'd1, 4'hF);
    read_chk("col_status0", 4'hC, 32'h0);
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);             // W, returns at W+1; match at W+12
    repeat (9) @(posedge clk); #1;            // W+10
    aw_issue(4'hC, 32'd1, 4'hF);              // W1C lands on W+12
    b_wait();                                 // W+13
    read_chk("col_w1c_vs_set", 4'hC, 32'h3);  // returns at W+16
    repeat (6) @(posedge clk); #1;            // W+22
    aw_issue(4'h4, 32'd7, 4'hF);              // TIME write lands on W+24 tick
    b_wait();                                 // W+25
    @(posedge clk); #1;                       // W+26
    read_chk("col_time7", 4'h4, 32'd7);       // sampled after W+27
    read_chk("col_next_tick", 4'h4, 32'd8);   // sampled after W+30 (tick at W+28)

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
